// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for a weight-stationary systolic array:
// weight load, skewed activation feed, valid taps, deskewed write-back.
module systolic_seq_ctrl #(
  parameter int DIM    = 4,
  parameter int RW     = 2,
  parameter int KW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          hold,
  output logic          busy,
  output logic          array_en,
  output logic          wload_en,
  output logic [RW-1:0] wload_row,
  output logic          act_rd_en,
  output logic [KW-1:0] act_rd_addr,
  output logic [DIM-1:0] act_row_en,
  output logic [DIM-1:0] out_col_valid,
  output logic          out_valid,
  output logic [KW-1:0] out_wr_addr,
  output logic          done
);

  localparam int DL  = RD_LAT + 2*DIM - 1;
  localparam int DCW = $clog2(DL + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, FEED, DRAIN, DONE
  } state_t;

  state_t         state, state_nx;
  logic [KW-1:0]  klen_q;
  logic [KW-1:0]  rd_addr_q;
  logic [KW-1:0]  wr_addr_q;
  logic [RW-1:0]  row_q;
  logic [DCW-1:0] dcnt_q;
  logic [DL-1:0]  vsr_q;

  // Every register, including the valid pipe, freezes under hold
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state     <= IDLE;
      klen_q    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      row_q     <= '0;
      dcnt_q    <= '0;
      vsr_q     <= '0;
    end else if (!hold) begin
      state <= state_nx;
      vsr_q <= {vsr_q[DL-2:0], act_rd_en};
      if (out_valid)
        wr_addr_q <= wr_addr_q + KW'(1);
      unique case (state)
        IDLE: begin
          if (start) begin
            klen_q    <= k_len;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            row_q     <= '0;
            dcnt_q    <= '0;
          end
        end
        LOAD_W: begin
          if (row_q != RW'(DIM-1))
            row_q <= row_q + RW'(1);
        end
        FEED: begin
          if (rd_addr_q != klen_q - KW'(1))
            rd_addr_q <= rd_addr_q + KW'(1);
        end
        DRAIN: dcnt_q <= dcnt_q + DCW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = LOAD_W;
      LOAD_W: begin
        if (row_q == RW'(DIM-1))
          state_nx = (klen_q != '0) ? FEED : DONE;
      end
      FEED: begin
        if (rd_addr_q == klen_q - KW'(1))
          state_nx = DRAIN;
      end
      DRAIN:  if (dcnt_q == DCW'(DL-1)) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    array_en    = busy & ~hold;
    wload_en    = (state == LOAD_W) & ~hold;
    act_rd_en   = (state == FEED) & ~hold;
    done        = (state == DONE) & ~hold;
    wload_row   = row_q;
    act_rd_addr = rd_addr_q;
    out_wr_addr = wr_addr_q;
    act_row_en    = '0;
    out_col_valid = '0;
    // Tap r sits RD_LAT+r behind the read; column c a further DIM
    for (int i = 0; i < DIM; i++) begin
      act_row_en[i]    = vsr_q[RD_LAT-1+i] & array_en;
      out_col_valid[i] = vsr_q[RD_LAT+DIM-1+i] & array_en;
    end
    out_valid = out_col_valid[DIM-1];
  end

endmodule
